// File: rtl/alu_driver_pkg.sv
// alu_driver_pkg: shared widths, FSM state type and helpers
// for the ALU driver and its wait timer.
package alu_driver_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int OP_W       = 4;
    localparam int MOVI_W     = 2;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/alu_drv_timer.sv
// alu_drv_timer: wait-cycle counter for the ALU driver,
// cleared in ISSUE, counting in WAIT, expiring at TIMEOUT-1.
module alu_drv_timer
    import alu_driver_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    assign expire = (cnt == CNT_W'(TIMEOUT - 1));

    // count WAIT cycles; clear wins over enable
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_driver.sv
// alu_driver: request -> ALU issue -> result/timeout -> hold.
// Optional counters enabled by macro ALU_DRIVER_STATS_EN.
module alu_driver
    import alu_driver_pkg::*;
#(
    parameter int DATA_WIDTH = alu_driver_pkg::DATA_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VLD,
    output logic                  REQ_RDY,
    input  logic [OP_W-1:0]       REQ_OP,
    input  logic [MOVI_W-1:0]     REQ_MOVI,
    input  logic [DATA_WIDTH-1:0] REQ_A,
    input  logic [DATA_WIDTH-1:0] REQ_B,
    input  logic [DATA_WIDTH-1:0] REQ_MEM,
    input  logic [DATA_WIDTH-1:0] REQ_IMM,
    output logic                  ACT,
    output logic [OP_W-1:0]       OP,
    output logic [MOVI_W-1:0]     MOVI,
    output logic [DATA_WIDTH-1:0] REG_A,
    output logic [DATA_WIDTH-1:0] REG_B,
    output logic [DATA_WIDTH-1:0] MEM,
    output logic [DATA_WIDTH-1:0] IMM,
    output logic                  ALU_RDY,
    input  logic [DATA_WIDTH-1:0] EX_ALU,
    input  logic                  EX_ALU_VLD,
    output logic [DATA_WIDTH-1:0] RES_DATA,
    output logic                  RES_TO,
    output logic                  RES_VLD,
    input  logic                  RES_RDY,
`ifdef ALU_DRIVER_STATS_EN
    output logic [15:0]           OP_CNT,
    output logic [7:0]            TO_CNT,
`endif
    output logic                  ERR_SPUR
);

    state_t state;
    logic   tmr_clr;
    logic   tmr_en;
    logic   expire;

    assign tmr_clr = (state == ISSUE);
    assign tmr_en  = (state == WAIT);

    alu_drv_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk   (CLK),
        .rst   (RST),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .expire(expire)
    );

    // main FSM with registered handshake and ALU-side outputs
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            REQ_RDY  <= 1'b1;
            ACT      <= 1'b0;
            OP       <= '0;
            MOVI     <= '0;
            REG_A    <= '0;
            REG_B    <= '0;
            MEM      <= '0;
            IMM      <= '0;
            ALU_RDY  <= 1'b0;
            RES_DATA <= '0;
            RES_TO   <= 1'b0;
            RES_VLD  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (REQ_VLD) begin
                        state   <= ISSUE;
                        REQ_RDY <= 1'b0;
                        ACT     <= 1'b1;
                        OP      <= REQ_OP;
                        MOVI    <= REQ_MOVI;
                        REG_A   <= REQ_A;
                        REG_B   <= REQ_B;
                        MEM     <= REQ_MEM;
                        IMM     <= REQ_IMM;
                    end
                end
                ISSUE: begin
                    state   <= WAIT;
                    ACT     <= 1'b0;
                    ALU_RDY <= 1'b1;
                end
                WAIT: begin
                    if (EX_ALU_VLD) begin
                        state    <= HOLD;
                        ALU_RDY  <= 1'b0;
                        RES_DATA <= EX_ALU;
                        RES_TO   <= 1'b0;
                        RES_VLD  <= 1'b1;
                    end else if (expire) begin
                        state    <= HOLD;
                        ALU_RDY  <= 1'b0;
                        RES_DATA <= '0;
                        RES_TO   <= 1'b1;
                        RES_VLD  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (RES_RDY) begin
                        state   <= IDLE;
                        RES_VLD <= 1'b0;
                        REQ_RDY <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // sticky flag: ALU result strobe outside WAIT
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ERR_SPUR <= 1'b0;
        end else if (EX_ALU_VLD && state != WAIT) begin
            ERR_SPUR <= 1'b1;
        end
    end

`ifdef ALU_DRIVER_STATS_EN
    // saturating delivery / timeout counters, bumped at HOLD exit
    always_ff @(posedge CLK) begin
        if (!RST) begin
            OP_CNT <= '0;
            TO_CNT <= '0;
        end else if (state == HOLD && RES_RDY) begin
            OP_CNT <= sat_inc16(OP_CNT);
            if (RES_TO) begin
                TO_CNT <= sat_inc8(TO_CNT);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: randomized scoreboard bench for alu_driver,
// bench plays requester, ALU and result consumer.
module tb_alu_driver;
    import alu_driver_pkg::*;

    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          REQ_VLD = 1'b0;
    logic          REQ_RDY;
    logic [3:0]    REQ_OP = '0;
    logic [1:0]    REQ_MOVI = '0;
    logic [DW-1:0] REQ_A = '0;
    logic [DW-1:0] REQ_B = '0;
    logic [DW-1:0] REQ_MEM = '0;
    logic [DW-1:0] REQ_IMM = '0;
    logic          ACT;
    logic [3:0]    OP;
    logic [1:0]    MOVI;
    logic [DW-1:0] REG_A;
    logic [DW-1:0] REG_B;
    logic [DW-1:0] MEM;
    logic [DW-1:0] IMM;
    logic          ALU_RDY;
    logic [DW-1:0] EX_ALU = '0;
    logic          EX_ALU_VLD = 1'b0;
    logic [DW-1:0] RES_DATA;
    logic          RES_TO;
    logic          RES_VLD;
    logic          RES_RDY = 1'b0;
    logic          ERR_SPUR;
`ifdef ALU_DRIVER_STATS_EN
    logic [15:0]   OP_CNT;
    logic [7:0]    TO_CNT;
`endif

    alu_driver #(
        .DATA_WIDTH(DW),
        .TIMEOUT   (TMO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VLD   (REQ_VLD),
        .REQ_RDY   (REQ_RDY),
        .REQ_OP    (REQ_OP),
        .REQ_MOVI  (REQ_MOVI),
        .REQ_A     (REQ_A),
        .REQ_B     (REQ_B),
        .REQ_MEM   (REQ_MEM),
        .REQ_IMM   (REQ_IMM),
        .ACT       (ACT),
        .OP        (OP),
        .MOVI      (MOVI),
        .REG_A     (REG_A),
        .REG_B     (REG_B),
        .MEM       (MEM),
        .IMM       (IMM),
        .ALU_RDY   (ALU_RDY),
        .EX_ALU    (EX_ALU),
        .EX_ALU_VLD(EX_ALU_VLD),
        .RES_DATA  (RES_DATA),
        .RES_TO    (RES_TO),
        .RES_VLD   (RES_VLD),
        .RES_RDY   (RES_RDY),
`ifdef ALU_DRIVER_STATS_EN
        .OP_CNT    (OP_CNT),
        .TO_CNT    (TO_CNT),
`endif
        .ERR_SPUR  (ERR_SPUR)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          to;
        int unsigned   at;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_busy = 0;
    bit   first_hold = 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // behavioural ALU: any deterministic function of the operands
    function automatic logic [DW-1:0] alu_ref(input logic [3:0] op,
        input logic [DW-1:0] a, input logic [DW-1:0] b,
        input logic [DW-1:0] imm);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return imm;
        endcase
    endfunction

    // d: WAIT-cycle index on which the ALU answers (>= TMO: never)
    task automatic do_req(input logic [3:0] op, input logic [1:0] movi,
        input logic [DW-1:0] a, input logic [DW-1:0] b,
        input logic [DW-1:0] mem, input logic [DW-1:0] imm,
        input int d, input bit push, input bit rst_w);
        int   waited;
        exp_t e;
        @(posedge CLK);
        #1;
        REQ_VLD  = 1'b1;
        REQ_OP   = op;
        REQ_MOVI = movi;
        REQ_A    = a;
        REQ_B    = b;
        REQ_MEM  = mem;
        REQ_IMM  = imm;
        waited   = 0;
        @(negedge CLK);
        while (!REQ_RDY && waited < 300) begin
            @(negedge CLK);
            waited++;
        end
        if (!REQ_RDY) begin
            chk("req_rdy_wait", REQ_RDY, 1);
            REQ_VLD = 1'b0;
            return;
        end
        if (d < TMO) begin
            e.data = alu_ref(op, a, b, imm);
            e.to   = 1'b0;
            e.at   = cyc + 3 + d;
        end else begin
            e.data = '0;
            e.to   = 1'b1;
            e.at   = cyc + 2 + TMO;
        end
        if (push) sbq.push_back(e);
        @(posedge CLK);
        #1;
        REQ_VLD  = 1'b0;
        REQ_OP   = 4'($urandom);
        REQ_MOVI = 2'($urandom);
        REQ_A    = DW'($urandom);
        REQ_B    = DW'($urandom);
        REQ_MEM  = DW'($urandom);
        REQ_IMM  = DW'($urandom);
        @(negedge CLK);
        chk("act_issue", ACT, 1);
        chk("req_rdy_issue", REQ_RDY, 0);
        chk("alu_rdy_issue", ALU_RDY, 0);
        chk("op", OP, op);
        chk("movi", MOVI, movi);
        chk("reg_a", REG_A, a);
        chk("reg_b", REG_B, b);
        chk("mem", MEM, mem);
        chk("imm", IMM, imm);
        @(negedge CLK);
        chk("act_wait", ACT, 0);
        chk("alu_rdy_wait", ALU_RDY, 1);
        chk("op_hold", OP, op);
        chk("reg_a_hold", REG_A, a);
        if (rst_w) begin
            repeat (d) @(negedge CLK);
            RST = 1'b0;
            @(posedge CLK);
            #1;
            RST = 1'b1;
            @(negedge CLK);
            chk("rstw_req_rdy", REQ_RDY, 1);
            chk("rstw_res_vld", RES_VLD, 0);
            chk("rstw_alu_rdy", ALU_RDY, 0);
            chk("rstw_act", ACT, 0);
            chk("rstw_op", OP, 0);
            chk("rstw_res_data", RES_DATA, 0);
            chk("rstw_err_spur", ERR_SPUR, 0);
            return;
        end
        if (d < TMO) begin
            repeat (d) @(negedge CLK);
            EX_ALU     = e.data;
            EX_ALU_VLD = 1'b1;
            @(posedge CLK);
            #1;
            EX_ALU_VLD = 1'b0;
            EX_ALU     = DW'($urandom) | DW'(1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || mon_busy) && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        chk("sb_drained", sbq.size(), 0);
    endtask

    // monitor: pop and compare whenever a result is presented
    initial begin
        exp_t e;
        int   hold;
        forever begin
            @(negedge CLK);
            if (RES_VLD) begin
                mon_busy = 1;
                if (sbq.size() == 0) begin
                    chk("unexpected_res_vld", RES_VLD, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("res_data", RES_DATA, e.data);
                    chk("res_to", RES_TO, e.to);
                    chk("latency_cycle", cyc, e.at);
                    hold = first_hold ? 10 : $urandom_range(0, 3);
                    first_hold = 0;
                    repeat (hold) begin
                        @(negedge CLK);
                        chk("hold_vld", RES_VLD, 1);
                        chk("hold_data", RES_DATA, e.data);
                        chk("hold_to", RES_TO, e.to);
                        chk("hold_req_rdy", REQ_RDY, 0);
                    end
                end
                RES_RDY = 1'b1;
                @(posedge CLK);
                #1;
                RES_RDY = 1'b0;
                @(negedge CLK);
                chk("vld_drop", RES_VLD, 0);
                chk("req_rdy_back", REQ_RDY, 1);
                mon_busy = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        EX_ALU = 8'h5A;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req_rdy", REQ_RDY, 1);
        chk("rst_act", ACT, 0);
        chk("rst_alu_rdy", ALU_RDY, 0);
        chk("rst_res_vld", RES_VLD, 0);
        chk("rst_res_data", RES_DATA, 0);
        chk("rst_err_spur", ERR_SPUR, 0);
`ifdef ALU_DRIVER_STATS_EN
        chk("rst_op_cnt", OP_CNT, 0);
`endif
        RST = 1'b1;

        do_req(4'd0, 2'd1, 8'd3, 8'd4, 8'd9, 8'd1, 2, 1, 0);
        do_req(4'd1, 2'd2, 8'd200, 8'd55, 8'd7, 8'd8, TMO - 1, 1, 0);
        do_req(4'd2, 2'd3, 8'hF0, 8'h3C, 8'd1, 8'd2, TMO, 1, 0);
        do_req(4'd4, 2'd0, 8'hAA, 8'h0F, 8'd5, 8'd6, 0, 1, 0);
        do_req(4'd3, 2'd1, 8'h12, 8'h34, 8'd5, 8'd6, TMO + 4, 1, 0);
        for (int i = 0; i < 25; i++) begin
            op = 4'($urandom_range(0, 6));
            do_req(op, 2'($urandom), DW'($urandom), DW'($urandom),
                   DW'($urandom), DW'($urandom),
                   $urandom_range(0, TMO + 2), 1, 0);
        end
        drain();
        chk("no_spur_main", ERR_SPUR, 0);

        @(negedge CLK);
        EX_ALU_VLD = 1'b1;
        @(posedge CLK);
        #1;
        EX_ALU_VLD = 1'b0;
        @(negedge CLK);
        chk("spur_set", ERR_SPUR, 1);
        chk("spur_req_rdy", REQ_RDY, 1);
        do_req(4'd0, 2'd0, 8'd10, 8'd20, 8'd0, 8'd0, 1, 1, 0);
        drain();
        chk("spur_sticky", ERR_SPUR, 1);

        do_req(4'd0, 2'd0, 8'd1, 8'd2, 8'd3, 8'd4, 3, 0, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (RES_VLD) chk("rstw_no_vld", RES_VLD, 0);
        end
        chk("rstw_idle_rdy", REQ_RDY, 1);

        do_req(4'd0, 2'd0, 8'd1, 8'd1, 8'd0, 8'd0, 0, 1, 0);
        do_req(4'd1, 2'd0, 8'd9, 8'd4, 8'd0, 8'd0, 5, 1, 0);
        do_req(4'd2, 2'd0, 8'd7, 8'd3, 8'd0, 8'd0, TMO, 1, 0);
        do_req(4'd3, 2'd0, 8'd8, 8'd1, 8'd0, 8'd0, 7, 1, 0);
        drain();
`ifdef ALU_DRIVER_STATS_EN
        chk("op_cnt", OP_CNT, 4);
        chk("to_cnt", TO_CNT, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
